// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with a
// HALT/RUN/DRAIN run-control FSM and a fairness limit on back-to-back data grants.
module mem_port_arbiter #(
   parameter int FAIR_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        exec,
   input  logic        halt_req,
   input  logic        if_req,
   input  logic [11:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [15:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [11:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [15:0] d_rdata,
   output logic [11:0] m_addr,
   output logic [15:0] m_data,
   output logic        m_rw,
   input  logic [15:0] m_q,
   output logic        run,
   output logic        stall
);

   localparam int CW = $clog2(FAIR_LIMIT + 1);

   typedef enum logic [1:0] {HALT, RUN, DRAIN} state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [CW-1:0]   r_fairCnt;
   logic [CW-1:0]   w_fairNext;
   logic            r_tagIf;
   logic            r_tagD;
   logic            w_fairHit;
   logic            w_run;

   assign w_run     = (r_state == RUN);
   assign w_fairHit = (r_fairCnt == CW'(FAIR_LIMIT));

   // State register; reset parks the processor in HALT until exec arrives.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= HALT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // DRAIN is a fixed one-cycle landing slot for a read granted in the last RUN cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         HALT:    if (exec) w_nextState = RUN;
         RUN:     if (exec || halt_req) w_nextState = DRAIN;
         DRAIN:   w_nextState = HALT;
         default: w_nextState = HALT;
      endcase
   end

   // Data normally wins; the fetch takes over once data has starved it FAIR_LIMIT times.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_rw   = 1'b0;
      if (w_run) begin
         if (if_req && (!d_req || w_fairHit)) begin
            if_gnt = 1'b1;
            m_addr = if_addr;
         end else if (d_req) begin
            d_gnt  = 1'b1;
            m_addr = d_addr;
            m_data = d_wdata;
            m_rw   = d_we;
         end
      end
   end

   // A streak only continues while data is granted over a waiting fetch.
   always_comb begin
      w_fairNext = '0;
      if (d_gnt && if_req) begin
         w_fairNext = w_fairHit ? r_fairCnt : r_fairCnt + CW'(1);
      end
   end

   // Fairness counter and read tags; the tags mark which requester owns m_q next cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_fairCnt <= '0;
         r_tagIf   <= 1'b0;
         r_tagD    <= 1'b0;
      end else begin
         r_fairCnt <= w_fairNext;
         r_tagIf   <= if_gnt;
         r_tagD    <= d_gnt && !d_we;
      end
   end

   assign if_rvalid = r_tagIf;
   assign d_rvalid  = r_tagD;
   assign if_rdata  = r_tagIf ? m_q : 16'h0000;
   assign d_rdata   = r_tagD  ? m_q : 16'h0000;
   assign run       = w_run;
   assign stall     = w_run ? (if_req && !if_gnt) : 1'b1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle checked against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int FAIR_LIMIT = 4;
   localparam int M_HALT  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        exec, halt_req, if_req, d_req, d_we;
   logic [11:0] if_addr, d_addr;
   logic [15:0] d_wdata, m_q;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, m_rw, run, stall;
   logic [15:0] if_rdata, d_rdata, m_data;
   logic [11:0] m_addr;

   int checks = 0;
   int errors = 0;

   int mState;
   int mCnt;
   bit mPendIf, mPendD;
   bit gIf, gD;

   mem_port_arbiter #(.FAIR_LIMIT(FAIR_LIMIT)) dut (
      .clock(clock), .reset(reset), .exec(exec), .halt_req(halt_req),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw), .m_q(m_q),
      .run(run), .stall(stall)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic resetModel();
      mState  = M_HALT;
      mCnt    = 0;
      mPendIf = 0;
      mPendD  = 0;
   endtask

   // Expected outputs come from the current inputs plus the model's state and pending reads.
   task automatic checkOutput();
      bit          eRun, eIfG, eDG, eRw, eStall;
      logic [11:0] eAddr;
      logic [15:0] eData;
      eRun  = (mState == M_RUN);
      eIfG  = eRun && if_req && (!d_req || mCnt == FAIR_LIMIT);
      eDG   = eRun && d_req && !eIfG;
      eAddr = eIfG ? if_addr : (eDG ? d_addr : 12'h000);
      eData = eDG ? d_wdata : 16'h0000;
      eRw   = eDG && d_we;
      eStall = eRun ? (if_req && !eIfG) : 1'b1;
      gIf = eIfG;
      gD  = eDG;
      check("run",       16'(run),       16'(eRun));
      check("if_gnt",    16'(if_gnt),    16'(eIfG));
      check("d_gnt",     16'(d_gnt),     16'(eDG));
      check("m_addr",    16'(m_addr),    16'(eAddr));
      check("m_data",    m_data,         eData);
      check("m_rw",      16'(m_rw),      16'(eRw));
      check("stall",     16'(stall),     16'(eStall));
      check("if_rvalid", 16'(if_rvalid), 16'(mPendIf));
      check("if_rdata",  if_rdata,       mPendIf ? m_q : 16'h0000);
      check("d_rvalid",  16'(d_rvalid),  16'(mPendD));
      check("d_rdata",   d_rdata,        mPendD ? m_q : 16'h0000);
   endtask

   // Clock edge: commit the grants decided by checkOutput and move the run state.
   task automatic advance();
      @(posedge clock);
      if (!reset) begin
         mPendIf = gIf;
         mPendD  = gD && !d_we;
         if (gIf || !if_req)  mCnt = 0;
         else if (gD)         mCnt = (mCnt + 1 > FAIR_LIMIT) ? FAIR_LIMIT : mCnt + 1;
         else                 mCnt = 0;
         case (mState)
            M_HALT:  if (exec) mState = M_RUN;
            M_RUN:   if (exec || halt_req) mState = M_DRAIN;
            default: mState = M_HALT;
         endcase
      end
      #1;
   endtask

   task automatic applyStimulus(input logic ex, input logic hr, input logic ir,
                                input logic [11:0] ia, input logic dr, input logic dw,
                                input logic [11:0] da, input logic [15:0] dd,
                                input logic [15:0] q);
      exec = ex; halt_req = hr; if_req = ir; if_addr = ia;
      d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; m_q = q;
      #1;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      #1;
      resetModel();
      checkOutput();
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      resetModel();
      applyStimulus(0, 0, 0, 12'h0, 0, 0, 12'h0, 16'h0, 16'h1234);
      checkOutput();
      check("reset_stall", 16'(stall), 16'h1);
      check("reset_run",   16'(run),   16'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      $display("[TB] fetch after exec");
      applyStimulus(0, 0, 1, 12'h005, 0, 0, 12'h0, 16'h0, 16'h0);
      checkOutput();
      check("halt_holds", 16'(if_gnt), 16'h0);
      advance();
      applyStimulus(1, 0, 0, 12'h0, 0, 0, 12'h0, 16'h0, 16'h0);
      checkOutput(); advance();
      applyStimulus(0, 0, 1, 12'h005, 0, 0, 12'h0, 16'h0, 16'h0);
      checkOutput();
      check("s1_run",    16'(run),    16'h1);
      check("s1_if_gnt", 16'(if_gnt), 16'h1);
      check("s1_m_addr", 16'(m_addr), 16'h0005);
      advance();
      applyStimulus(0, 0, 0, 12'h0, 0, 0, 12'h0, 16'h0, 16'hA123);
      checkOutput();
      check("s1_if_rvalid", 16'(if_rvalid), 16'h1);
      check("s1_if_rdata",  if_rdata,       16'hA123);
      advance();

      $display("[TB] store beats fetch");
      applyStimulus(0, 0, 1, 12'h007, 1, 1, 12'h100, 16'hBEEF, 16'h0);
      checkOutput();
      check("s2_d_gnt",  16'(d_gnt),  16'h1);
      check("s2_m_rw",   16'(m_rw),   16'h1);
      check("s2_m_addr", 16'(m_addr), 16'h0100);
      check("s2_m_data", m_data,      16'hBEEF);
      check("s2_stall",  16'(stall),  16'h1);
      advance();
      applyStimulus(0, 0, 0, 12'h0, 0, 0, 12'h0, 16'h0, 16'h7777);
      checkOutput();
      check("s2_no_rvalid", 16'(d_rvalid), 16'h0);
      advance();

      $display("[TB] fairness");
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 0, 1, 12'h020 + 12'(k), 1, 0, 12'h200 + 12'(k), 16'h0, 16'(k));
         checkOutput();
         check("s3_if_gnt", 16'(if_gnt), (k == 4) ? 16'h1 : 16'h0);
         check("s3_d_gnt",  16'(d_gnt),  (k == 4) ? 16'h0 : 16'h1);
         advance();
      end

      $display("[TB] load with halt, exec during drain");
      applyStimulus(0, 1, 0, 12'h0, 1, 0, 12'h0AB, 16'h0, 16'h0);
      checkOutput();
      check("s4_d_gnt", 16'(d_gnt), 16'h1);
      advance();
      applyStimulus(1, 0, 0, 12'h0, 0, 0, 12'h0, 16'h0, 16'h5A5A);
      checkOutput();
      check("s4_run",      16'(run),      16'h0);
      check("s4_d_rvalid", 16'(d_rvalid), 16'h1);
      check("s4_d_rdata",  d_rdata,       16'h5A5A);
      advance();
      applyStimulus(0, 0, 1, 12'h011, 1, 0, 12'h022, 16'h0, 16'h6B6B);
      checkOutput();
      check("s5_halt_run",   16'(run),      16'h0);
      check("s5_halt_gnt",   16'(if_gnt | d_gnt), 16'h0);
      check("s5_halt_stall", 16'(stall),    16'h1);
      check("s5_halt_rv",    16'(d_rvalid | if_rvalid), 16'h0);
      advance();
      applyStimulus(1, 0, 0, 12'h0, 0, 0, 12'h0, 16'h0, 16'h0);
      checkOutput(); advance();
      applyStimulus(0, 0, 0, 12'h0, 0, 0, 12'h0, 16'h0, 16'h0);
      checkOutput();
      check("s5_rerun", 16'(run), 16'h1);
      advance();

      $display("[TB] reset mid-read");
      applyStimulus(0, 0, 1, 12'h03C, 0, 0, 12'h0, 16'h0, 16'h0);
      checkOutput();
      check("s6_if_gnt", 16'(if_gnt), 16'h1);
      advance();
      m_q = 16'hC0DE;
      applyReset();
      applyStimulus(0, 0, 1, 12'h03C, 1, 1, 12'h0, 16'h0, 16'hC0DE);
      checkOutput();
      check("s6_stay_halt", 16'(run), 16'h0);
      advance();

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            applyReset();
         end
         applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 9) < 6, 12'($urandom), $urandom_range(0, 9) < 7,
                       1'($urandom), 12'($urandom), 16'($urandom), 16'($urandom));
         checkOutput();
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have the following parameter: FAIR_LIMIT, default 4, maximum consecutive data grants while a fetch is pending.
REQ-002 The block SHALL have the following ports, in this order:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- exec  in  1  one-cycle run/stop toggle pulse
- halt_req  in  1  halt instruction decoded
- if_req  in  1  fetch request
- if_addr  in  12  fetch address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  16  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  12  data address
- d_wdata  in  16  store data
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  16  load data
- m_addr  out  12  memory address
- m_data  out  16  memory write data
- m_rw  out  1  memory write enable
- m_q  in  16  memory read data, valid one cycle after the address
- run  out  1  processor running
- stall  out  1  fetch stage must hold its PC and IR

Function
REQ-003 The block SHALL implement the states HALT, RUN and DRAIN.
REQ-004 In HALT, an exec pulse SHALL move the state to RUN; halt_req SHALL be ignored.
REQ-005 In RUN, exec or halt_req (either or both) SHALL move the state to DRAIN.
REQ-006 DRAIN SHALL last exactly one cycle, SHALL then move to HALT, and SHALL ignore exec.
REQ-007 The run output SHALL be 1 only in RUN.
REQ-008 Grants SHALL be issued only in RUN; if_gnt and d_gnt SHALL be combinational from the requests and the state.
REQ-009 The block SHALL never assert if_gnt and d_gnt in the same cycle.
REQ-010 Priority: d_req SHALL win over if_req, except as stated in REQ-011.
REQ-011 Fairness: a counter SHALL count consecutive cycles in which d_gnt=1 while if_req=1.
- When the counter equals FAIR_LIMIT and if_req=1, the fetch SHALL be granted instead of the data request.
- The counter SHALL clear on any fetch grant and on any cycle with if_req=0.
- The counter SHALL saturate at FAIR_LIMIT.
REQ-012 Memory drive on a fetch grant: m_addr=if_addr, m_rw=0.
REQ-013 Memory drive on a data grant: m_addr=d_addr, m_rw=d_we, m_data=d_wdata.
REQ-014 With no grant, m_addr, m_data and m_rw SHALL all be 0.
REQ-015 The memory drive outputs SHALL be combinational in the same cycle as the grant.
REQ-016 A registered read tag SHALL record a read grant (fetch, or data with d_we=0).
- For a fetch read granted in cycle N, if_rvalid SHALL be 1 in cycle N+1 with if_rdata=m_q.
- For a data read granted in cycle N, d_rvalid SHALL be 1 in cycle N+1 with d_rdata=m_q.
- A data store SHALL produce no rvalid.
REQ-017 When the corresponding rvalid is 0, if_rdata and d_rdata SHALL be 0.
REQ-018 A read granted in the last RUN cycle SHALL return its rvalid during DRAIN.
REQ-019 After DRAIN, no rvalid SHALL be asserted in HALT.
REQ-020 stall SHALL equal (if_req & ~if_gnt) in RUN, and SHALL be 1 in HALT and DRAIN.
REQ-021 A request held across cycles without a grant SHALL be re-arbitrated every cycle; the block SHALL store no request data.

Reset
REQ-022 While reset=1, the state SHALL be forced to HALT, the fairness counter cleared and the read tag cleared.
REQ-023 While reset=1, all outputs SHALL be 0 except stall, which SHALL be 1.
REQ-024 Reset asserted mid-read SHALL suppress that read's rvalid.
REQ-025 After reset deassertion, the block SHALL remain in HALT until an exec pulse.

Verification
REQ-026 The bench SHALL cover these scenarios:
- Reset, then exec pulse, then if_req=1 with if_addr=0x005 and m_q=0xA123 in the next cycle -> run=1; if_gnt=1 and m_addr=0x005 in cycle N; if_rvalid=1 and if_rdata=0xA123 in cycle N+1.
- if_req and d_req both 1, d_we=1, d_addr=0x100, d_wdata=0xBEEF -> d_gnt=1, m_rw=1, m_addr=0x100, m_data=0xBEEF, stall=1, no d_rvalid.
- if_req and d_req both held high for 6 cycles with FAIR_LIMIT=4 -> d_gnt in cycles 1-4, if_gnt in cycle 5, d_gnt in cycle 6.
- Load granted in the same cycle halt_req=1 -> next cycle state DRAIN, run=0, d_rvalid=1 with m_q data; the following cycle state HALT with no grants and stall=1.
- exec pulse while in DRAIN -> ignored; state reaches HALT; a second exec pulse in HALT -> RUN.
- Reset asserted the cycle after a fetch grant -> if_rvalid=0, run=0, m_rw=0, stall=1.
